tone_gen: RTL and testbench

Converts the 4-bit note code produced by the auto-play and keyboard note stages into a square-wave SPEAKER drive. It sits directly downstream of the note sequencer, in the CLK domain, and feeds the board audio pin.
- Frequency changes happen only at half-period boundaries, so the output never carries a runt pulse.
- A short silent articulation gap separates consecutive different notes.

---
 rtl/tone_gen_pkg.sv | 34 +++
 rtl/tone_gen_half_lut.sv | 29 ++
 rtl/tone_gen.sv | 119 +++++++++++
 tb/tb_tone_gen.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_gen_pkg.sv
// Shared constants for the tone generator: note codes, half-period constants
// at 100 MHz, and the playback FSM encoding.
package tone_gen_pkg;

    localparam logic [3:0] NOTE_C5   = 4'd0;
    localparam logic [3:0] NOTE_B    = 4'd1;
    localparam logic [3:0] NOTE_A    = 4'd2;
    localparam logic [3:0] NOTE_G    = 4'd3;
    localparam logic [3:0] NOTE_F    = 4'd4;
    localparam logic [3:0] NOTE_E    = 4'd5;
    localparam logic [3:0] NOTE_D    = 4'd6;
    localparam logic [3:0] NOTE_C4   = 4'd7;
    localparam logic [3:0] NOTE_NONE = 4'd8;

    localparam logic [17:0] HALF_C4 = 18'd191113;
    localparam logic [17:0] HALF_D  = 18'd170265;
    localparam logic [17:0] HALF_E  = 18'd151686;
    localparam logic [17:0] HALF_F  = 18'd143172;
    localparam logic [17:0] HALF_G  = 18'd127551;
    localparam logic [17:0] HALF_A  = 18'd113636;
    localparam logic [17:0] HALF_B  = 18'd101239;
    localparam logic [17:0] HALF_C5 = 18'd95557;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } tone_state_e;

    function automatic logic note_valid(input logic [3:0] code);
        return code <= NOTE_C4;
    endfunction

endpackage

// File: rtl/tone_gen_half_lut.sv
// Combinational note code to half-period lookup, scaled down by DIV_SHIFT.
module tone_half_lut
    import tone_gen_pkg::*;
#(
    parameter int DIV_SHIFT = 0
) (
    input  logic [3:0]  code,
    output logic [17:0] half
);

    logic [17:0] half_raw;

    always_comb begin
        unique case (code)
            NOTE_C5: half_raw = HALF_C5;
            NOTE_B:  half_raw = HALF_B;
            NOTE_A:  half_raw = HALF_A;
            NOTE_G:  half_raw = HALF_G;
            NOTE_F:  half_raw = HALF_F;
            NOTE_E:  half_raw = HALF_E;
            NOTE_D:  half_raw = HALF_D;
            NOTE_C4: half_raw = HALF_C4;
            // Silent codes are never loaded into the counter.
            default: half_raw = 18'd0;
        endcase
        half = half_raw >> DIV_SHIFT;
    end

endmodule

// File: rtl/tone_gen.sv
// Square-wave speaker driver: plays the registered note code, switching notes
// only at half-period boundaries with a silent gap between different notes.
module tone_gen
    import tone_gen_pkg::*;
#(
    parameter int GAP_CYCLES = 500000,
    parameter int DIV_SHIFT  = 0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] note,
    input  logic       MUTE,
    output logic       SPEAKER,
    output logic       sounding,
    output logic [3:0] cur_note
);

    localparam logic [18:0] GAP_LOAD = 19'(GAP_CYCLES - 1);

    tone_state_e state_q, state_d;
    logic [18:0] cnt_q, cnt_d;
    logic        spk_q, spk_d;
    logic [3:0]  cur_note_q, cur_note_d;
    logic [3:0]  note_q, note_d;

    logic [3:0]  lut_code;
    logic [17:0] half;
    logic [18:0] half_load;
    logic        change_pending;

    // PLAY reloads from the note in progress; IDLE and GAP start the incoming one.
    assign lut_code = (state_q == ST_PLAY) ? cur_note_q : note_q;

    tone_half_lut #(.DIV_SHIFT(DIV_SHIFT)) u_half_lut (
        .code (lut_code),
        .half (half)
    );

    always_comb begin
        note_d         = (MUTE || note > NOTE_NONE) ? NOTE_NONE : note;
        half_load      = {1'b0, half} - 19'd1;
        change_pending = (note_q != cur_note_q);
    end

    // NOTE: synchronous reset inside the clocked block; <= keeps every flop
    // sampling pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            spk_q      <= 1'b0;
            cur_note_q <= NOTE_NONE;
            note_q     <= NOTE_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            spk_q      <= spk_d;
            cur_note_q <= cur_note_d;
            note_q     <= note_d;
        end
    end

    always_comb begin
        // NOTE: hold-by-default assignments first, so no path infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        spk_d      = spk_q;
        cur_note_d = cur_note_q;

        unique case (state_q)
            ST_IDLE, ST_GAP: begin
                spk_d      = 1'b0;
                cur_note_d = NOTE_NONE;
                if (state_q == ST_GAP && cnt_q != '0) begin
                    cnt_d = cnt_q - 19'd1;
                end else if (note_valid(note_q)) begin
                    state_d    = ST_PLAY;
                    cur_note_d = note_q;
                    spk_d      = 1'b1;
                    cnt_d      = half_load;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 19'd1;
                end else if (!change_pending) begin
                    spk_d = ~spk_q;
                    cnt_d = half_load;
                end else begin
                    // Forcing low rather than toggling lets a low phase run on into the gap.
                    spk_d      = 1'b0;
                    cur_note_d = NOTE_NONE;
                    if (note_valid(note_q)) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                spk_d      = 1'b0;
                cur_note_d = NOTE_NONE;
                cnt_d      = '0;
            end
        endcase
    end

    always_comb begin
        SPEAKER  = spk_q;
        sounding = (state_q == ST_PLAY);
        cur_note = cur_note_q;
    end

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen at DIV_SHIFT=10, GAP_CYCLES=16 (E=148, G=124),
// plus a full-scale check of the half-period table.
module tb_tone_gen;

    logic        CLK;
    logic        RESET;
    logic [3:0]  note;
    logic        MUTE;
    logic        SPEAKER;
    logic        sounding;
    logic [3:0]  cur_note;

    logic [3:0]  lut_code;
    logic [17:0] lut_half;

    int n_checks = 0;
    int n_fail   = 0;

    tone_gen #(.GAP_CYCLES(16), .DIV_SHIFT(10)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .note     (note),
        .MUTE     (MUTE),
        .SPEAKER  (SPEAKER),
        .sounding (sounding),
        .cur_note (cur_note)
    );

    tone_half_lut #(.DIV_SHIFT(0)) u_lut_full (
        .code (lut_code),
        .half (lut_half)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits (bounded) for SPEAKER==level at a falling edge.
    task automatic wait_level(input logic level, output bit ok);
        int guard = 0;
        while (SPEAKER !== level && guard < 2000) begin
            @(negedge CLK);
            guard++;
        end
        ok = (SPEAKER === level);
    endtask

    // Counts falling-edge samples of one SPEAKER level, starting with the current one; -1 on timeout.
    task automatic measure(input logic level, output int n);
        bit ok;
        wait_level(level, ok);
        if (!ok) begin
            n = -1;
        end else begin
            n = 0;
            while (SPEAKER === level && n < 2000) begin
                n++;
                @(negedge CLK);
            end
        end
    endtask

    task automatic quiet_cycles(input string name, input int cycles);
        int edges = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            if (SPEAKER !== 1'b0) edges++;
        end
        n_checks++;
        if (edges !== 0) begin
            $display("FAIL %s: %0d high samples while idle, required 0", name, edges);
            n_fail++;
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        note  = 4'd5;
        MUTE  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_checks++;
            if (SPEAKER !== 1'b0 || sounding !== 1'b0 || cur_note !== 4'd8) begin
                $display("FAIL reset_hold[%0d]: spk=%b snd=%b cur=%0d, required 0 0 8",
                         i, SPEAKER, sounding, cur_note);
                n_fail++;
            end
        end
        RESET = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (SPEAKER !== 1'b0 || sounding !== 1'b0) begin
            $display("FAIL reset_release_1: spk=%b snd=%b, required 0 0", SPEAKER, sounding);
            n_fail++;
        end
        @(negedge CLK);
        n_checks++;
        if (SPEAKER !== 1'b1 || sounding !== 1'b1 || cur_note !== 4'd5) begin
            $display("FAIL reset_release_2: spk=%b snd=%b cur=%0d, required 1 1 5",
                     SPEAKER, sounding, cur_note);
            n_fail++;
        end
    endtask

    task automatic test_steady;
        int n;
        int exp_len [3] = '{148, 148, 148};
        logic lvl [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (sounding !== 1'b1 || cur_note !== 4'd5) begin
                $display("FAIL steady_status[%0d]: snd=%b cur=%0d, required 1 5", i, sounding, cur_note);
                n_fail++;
            end
            measure(lvl[i], n);
            n_checks++;
            if (n !== exp_len[i]) begin
                $display("FAIL steady_len[%0d]: %0d cycles at level %b, required %0d",
                         i, n, lvl[i], exp_len[i]);
                n_fail++;
            end
        end
    endtask

    task automatic test_change_mid_high;
        int n;
        measure(1'b0, n);
        n_checks++;
        if (n !== 148) begin
            $display("FAIL chg_pre_low: %0d cycles, required 148", n);
            n_fail++;
        end
        repeat (49) @(negedge CLK);
        note = 4'd3;
        measure(1'b1, n);
        n_checks++;
        if (49 + n !== 148) begin
            $display("FAIL chg_high_len: %0d cycles, required 148", 49 + n);
            n_fail++;
        end
        n_checks++;
        if (cur_note !== 4'd8 || sounding !== 1'b0) begin
            $display("FAIL chg_gap_status: cur=%0d snd=%b, required 8 0", cur_note, sounding);
            n_fail++;
        end
        measure(1'b0, n);
        n_checks++;
        if (n !== 16) begin
            $display("FAIL chg_gap_len: %0d cycles, required 16", n);
            n_fail++;
        end
        n_checks++;
        if (cur_note !== 4'd3 || sounding !== 1'b1) begin
            $display("FAIL chg_new_status: cur=%0d snd=%b, required 3 1", cur_note, sounding);
            n_fail++;
        end
        for (int i = 0; i < 2; i++) begin
            measure(i == 0 ? 1'b1 : 1'b0, n);
            n_checks++;
            if (n !== 124) begin
                $display("FAIL chg_g_len[%0d]: %0d cycles, required 124", i, n);
                n_fail++;
            end
        end
    endtask

    task automatic test_change_mid_low;
        int n;
        measure(1'b1, n);
        n_checks++;
        if (n !== 124) begin
            $display("FAIL low_chg_pre_high: %0d cycles, required 124", n);
            n_fail++;
        end
        repeat (9) @(negedge CLK);
        note = 4'd5;
        measure(1'b0, n);
        n_checks++;
        if (9 + n !== 140) begin
            $display("FAIL low_chg_low_len: %0d cycles, required 140", 9 + n);
            n_fail++;
        end
        n_checks++;
        if (cur_note !== 4'd5) begin
            $display("FAIL low_chg_cur: cur=%0d, required 5", cur_note);
            n_fail++;
        end
        measure(1'b1, n);
        n_checks++;
        if (n !== 148) begin
            $display("FAIL low_chg_e_high: %0d cycles, required 148", n);
            n_fail++;
        end
    endtask

    task automatic test_stop;
        int n;
        bit ok;
        repeat (10) @(negedge CLK);
        note = 4'd8;
        repeat (137) @(negedge CLK);
        n_checks++;
        if (sounding !== 1'b1 || SPEAKER !== 1'b0) begin
            $display("FAIL stop_last_low: snd=%b spk=%b, required 1 0", sounding, SPEAKER);
            n_fail++;
        end
        @(negedge CLK);
        n_checks++;
        if (sounding !== 1'b0 || cur_note !== 4'd8 || SPEAKER !== 1'b0) begin
            $display("FAIL stop_idle: snd=%b cur=%0d spk=%b, required 0 8 0", sounding, cur_note, SPEAKER);
            n_fail++;
        end
        quiet_cycles("stop_quiet", 300);

        note = 4'd3;
        wait_level(1'b1, ok);
        MUTE = 1'b1;
        measure(1'b1, n);
        n_checks++;
        if (n !== 124) begin
            $display("FAIL mute_high_len: %0d cycles, required 124", n);
            n_fail++;
        end
        n_checks++;
        if (sounding !== 1'b0 || cur_note !== 4'd8) begin
            $display("FAIL mute_idle: snd=%b cur=%0d, required 0 8", sounding, cur_note);
            n_fail++;
        end
        quiet_cycles("mute_quiet", 200);

        MUTE = 1'b0;
        wait_level(1'b1, ok);
        note = 4'd12;
        measure(1'b1, n);
        n_checks++;
        if (n !== 124) begin
            $display("FAIL code12_high_len: %0d cycles, required 124", n);
            n_fail++;
        end
        n_checks++;
        if (sounding !== 1'b0 || cur_note !== 4'd8) begin
            $display("FAIL code12_idle: snd=%b cur=%0d, required 0 8", sounding, cur_note);
            n_fail++;
        end
        quiet_cycles("code12_quiet", 200);
    endtask

    task automatic test_reset_mid;
        int n;
        bit ok;
        note = 4'd5;
        wait_level(1'b1, ok);
        repeat (29) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (SPEAKER !== 1'b0 || sounding !== 1'b0 || cur_note !== 4'd8) begin
            $display("FAIL rst_mid: spk=%b snd=%b cur=%0d, required 0 0 8", SPEAKER, sounding, cur_note);
            n_fail++;
        end
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (SPEAKER !== 1'b0) begin
            $display("FAIL rst_mid_release_1: spk=%b, required 0", SPEAKER);
            n_fail++;
        end
        @(negedge CLK);
        n_checks++;
        if (SPEAKER !== 1'b1 || cur_note !== 4'd5) begin
            $display("FAIL rst_mid_release_2: spk=%b cur=%0d, required 1 5", SPEAKER, cur_note);
            n_fail++;
        end
        measure(1'b1, n);
        n_checks++;
        if (n !== 148) begin
            $display("FAIL rst_mid_first_half: %0d cycles, required 148", n);
            n_fail++;
        end
    endtask

    task automatic test_full_scale_lut;
        int exp_half [8] = '{95557, 101239, 113636, 127551, 143172, 151686, 170265, 191113};
        for (int i = 0; i < 8; i++) begin
            lut_code = 4'(i);
            #1;
            n_checks++;
            if (lut_half !== 18'(exp_half[i])) begin
                $display("FAIL full_half[%0d]: %0d, required %0d", i, lut_half, exp_half[i]);
                n_fail++;
            end
        end
    endtask

    initial begin
        lut_code = 4'd8;
        test_reset();
        test_steady();
        test_change_mid_high();
        test_change_mid_low();
        test_stop();
        test_reset_mid();
        test_full_scale_lut();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
